food_map_ctrl: RTL and testbench



---
 rtl/food_map_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_food_map_ctrl.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/food_map_ctrl.sv
// food_map_ctrl: 80x60 pellet bitmap with eat handling, BCD score and count.
// The renderer reads one registered row per cycle on the food port.
module food_map_ctrl #(
    parameter int ROWS = 60,
    parameter int COLS = 80
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [5:0]      food_idx_y,
    output logic [COLS-1:0] food_row,
    input  logic            eat_valid,
    input  logic [6:0]      eat_x,
    input  logic [5:0]      eat_y,
    output logic            eat_ready,
    output logic            eat_done,
    output logic            eat_hit,
    input  logic            restart,
    output logic [15:0]     score_bcd,
    output logic [12:0]     pellets_left,
    output logic            all_eaten
);

    typedef enum logic [1:0] {S_INIT, S_IDLE, S_READ, S_WRITE} state_t;

    localparam int NPEL = ((COLS + 1) / 4) * ((ROWS + 1) / 4);
    localparam logic [12:0]     NPEL_W   = 13'(NPEL);
    localparam logic [6:0]      COLS_W   = 7'(COLS);
    localparam logic [5:0]      ROWS_W   = 6'(ROWS);
    localparam logic [5:0]      LAST_ROW = 6'(ROWS - 1);
    localparam logic [COLS-1:0] BIT0     = COLS'(1);

    // Pellets sit on every 4th column/row, offset by 2.
    function automatic logic [COLS-1:0] pattern_row(input logic [1:0] ylo);
        logic [COLS-1:0] row;
        row = '0;
        for (int x = 0; x < COLS; x++)
            row[x] = (ylo == 2'd2) && (x % 4 == 2);
        return row;
    endfunction

    // Decimal +1 over four digits, pinned at 9999.
    function automatic logic [15:0] bcd_inc(input logic [15:0] s);
        logic [15:0] r;
        logic        carry;
        r     = s;
        carry = 1'b1;
        if (s != 16'h9999) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (r[4*i +: 4] == 4'd9) begin
                        r[4*i +: 4] = 4'd0;
                    end else begin
                        r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                        carry       = 1'b0;
                    end
                end
            end
        end
        return r;
    endfunction

    state_t          r_state;
    state_t          w_state_nxt;
    logic [COLS-1:0] r_mem [ROWS];
    logic [5:0]      r_row_ctr;
    logic [6:0]      r_x;
    logic [5:0]      r_y;
    logic [COLS-1:0] r_hold;
    logic [COLS-1:0] r_food_row;
    logic            r_done;
    logic            r_hit;
    logic [15:0]     r_score;
    logic [12:0]     r_pellets;
    logic            r_all_eaten;
    logic            w_ready;
    logic            w_in_range;
    logic            w_hit;
    logic            w_last_row;
    logic            w_mem_we;
    logic [5:0]      w_mem_wa;
    logic [COLS-1:0] w_mem_wd;
    logic [12:0]     w_pellets_nxt;

    assign w_last_row = (r_row_ctr == LAST_ROW);
    assign w_in_range = (r_x < COLS_W) && (r_y < ROWS_W);
    assign w_hit      = (r_state == S_WRITE) && w_in_range
                        && r_hold[r_x] && !restart;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) r_state <= S_INIT;
        else     r_state <= w_state_nxt;
    end

    // Next state, ready and the single storage write port.
    always_comb begin
        w_state_nxt = r_state;
        w_ready     = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_wa    = r_row_ctr;
        w_mem_wd    = pattern_row(r_row_ctr[1:0]);
        unique case (r_state)
            S_INIT: begin
                w_mem_we = 1'b1;
                if (w_last_row) w_state_nxt = S_IDLE;
            end
            S_IDLE: begin
                w_ready = 1'b1;
                if (eat_valid) w_state_nxt = S_READ;
            end
            S_READ: w_state_nxt = S_WRITE;
            S_WRITE: begin
                w_state_nxt = S_IDLE;
                w_mem_we    = w_hit;
                w_mem_wa    = r_y;
                w_mem_wd    = r_hold & ~(BIT0 << r_x);
            end
            default: w_state_nxt = S_INIT;
        endcase
        if (restart) begin
            w_state_nxt = S_INIT;
            w_mem_we    = 1'b0;
        end
    end

    // Pellet count: cleared by restart, loaded at end of fill, -1 per hit.
    always_comb begin
        w_pellets_nxt = r_pellets;
        if (restart)
            w_pellets_nxt = '0;
        else if (r_state == S_INIT && w_last_row)
            w_pellets_nxt = NPEL_W;
        else if (w_hit)
            w_pellets_nxt = r_pellets - 13'd1;
    end

    // Bitmap storage; contents are rebuilt by INIT so no reset is needed.
    always_ff @(posedge clk) begin
        if (!rst && w_mem_we) r_mem[w_mem_wa] <= w_mem_wd;
    end

    // Datapath: render port, request latch, score and status registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_food_row  <= '0;
            r_row_ctr   <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_hold      <= '0;
            r_done      <= 1'b0;
            r_hit       <= 1'b0;
            r_score     <= '0;
            r_pellets   <= '0;
            r_all_eaten <= 1'b0;
        end else begin
            if (r_state == S_INIT || restart || food_idx_y >= ROWS_W)
                r_food_row <= '0;
            else
                r_food_row <= r_mem[food_idx_y];
            r_done      <= (r_state == S_WRITE) && !restart;
            r_hit       <= w_hit;
            r_pellets   <= w_pellets_nxt;
            r_all_eaten <= (w_pellets_nxt == '0) && (w_state_nxt != S_INIT);
            if (w_hit) r_score <= bcd_inc(r_score);
            if (restart) begin
                r_row_ctr <= '0;
            end else begin
                unique case (r_state)
                    S_INIT: r_row_ctr <= w_last_row ? '0 : r_row_ctr + 6'd1;
                    S_IDLE: begin
                        if (eat_valid) begin
                            r_x <= eat_x;
                            r_y <= eat_y;
                        end
                    end
                    S_READ: r_hold <= (r_y < ROWS_W) ? r_mem[r_y] : '0;
                    default: ;
                endcase
            end
        end
    end

    assign food_row     = r_food_row;
    assign eat_ready    = w_ready;
    assign eat_done     = r_done;
    assign eat_hit      = r_hit;
    assign score_bcd    = r_score;
    assign pellets_left = r_pellets;
    assign all_eaten    = r_all_eaten;

endmodule

// File: tb/tb_food_map_ctrl.sv
// tb_food_map_ctrl: randomized eats against a bitmap/score reference model,
// with a scoreboard queue drained by an independent done monitor.
module tb_food_map_ctrl;

    localparam int ROWS = 60;
    localparam int COLS = 80;

    logic            clk = 1'b0;
    logic            rst;
    logic [5:0]      food_idx_y;
    logic [COLS-1:0] food_row;
    logic            eat_valid;
    logic [6:0]      eat_x;
    logic [5:0]      eat_y;
    logic            eat_ready;
    logic            eat_done;
    logic            eat_hit;
    logic            restart;
    logic [15:0]     score_bcd;
    logic [12:0]     pellets_left;
    logic            all_eaten;

    food_map_ctrl #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .food_idx_y(food_idx_y), .food_row(food_row),
        .eat_valid(eat_valid), .eat_x(eat_x), .eat_y(eat_y),
        .eat_ready(eat_ready), .eat_done(eat_done), .eat_hit(eat_hit),
        .restart(restart), .score_bcd(score_bcd),
        .pellets_left(pellets_left), .all_eaten(all_eaten)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        hit;
        logic [15:0] score;
        logic [12:0] pel;
        logic        ae;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   done_cycs[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    bit map [ROWS][COLS];
    int m_score = 0;
    int m_pel   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] to_bcd(input int s);
        return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
    endfunction

    function automatic logic [COLS-1:0] model_row(input int y);
        logic [COLS-1:0] r;
        r = '0;
        if (y < ROWS)
            for (int x = 0; x < COLS; x++) r[x] = map[y][x];
        return r;
    endfunction

    function automatic void fill_model();
        m_pel = 0;
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++) begin
                map[y][x] = (x % 4 == 2) && (y % 4 == 2);
                if (map[y][x]) m_pel++;
            end
    endfunction

    task automatic chk(input string nm, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every completion is matched against the oldest expectation.
    always @(negedge clk) begin
        if (eat_done) begin
            checks++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                if ({eat_hit, score_bcd, pellets_left, all_eaten} !== mon_e) begin
                    fails++;
                    $display("FAIL eat_result: got hit=%0b score=%h left=%0d ae=%0b expected hit=%0b score=%h left=%0d ae=%0b",
                             eat_hit, score_bcd, pellets_left, all_eaten,
                             mon_e.hit, mon_e.score, mon_e.pel, mon_e.ae);
                end
            end
            done_cycs.push_back(cyc);
        end
    end

    task automatic do_eat(input int x, input int y, input bit hold);
        int   n;
        bit   h;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!eat_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (!eat_ready) begin
            chk("eat_ready_timeout", 128'(eat_ready), 128'(1));
            eat_valid = 1'b0;
            return;
        end
        eat_valid = 1'b1;
        eat_x     = 7'(x);
        eat_y     = 6'(y);
        h = 1'b0;
        if (x < COLS && y < ROWS) h = map[y][x];
        if (h) begin
            map[y][x] = 1'b0;
            m_pel--;
            if (m_score < 9999) m_score++;
        end
        e.hit   = h;
        e.score = to_bcd(m_score);
        e.pel   = 13'(m_pel);
        e.ae    = (m_pel == 0);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (!hold) eat_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || !eat_ready) && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 128'(exp_q.size()), 128'(0));
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        @(negedge clk);
        while (!eat_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ready_wait", 128'(eat_ready), 128'(1));
    endtask

    task automatic check_row(input int y);
        @(negedge clk);
        food_idx_y = 6'(y);
        @(posedge clk);
        @(negedge clk);
        chk($sformatf("row%0d", y), 128'(food_row), 128'(model_row(y)));
    endtask

    task automatic eat_all();
        for (int y = 0; y < ROWS; y++)
            for (int x = 0; x < COLS; x++)
                if (map[y][x]) do_eat(x, y, 1'b0);
        wait_idle();
    endtask

    task automatic do_restart(input bit detail);
        @(negedge clk);
        food_idx_y = 6'd2;
        restart    = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        fill_model();
        if (detail) begin
            for (int i = 1; i <= 60; i++) begin
                @(negedge clk);
                chk($sformatf("restart_init_%0d", i),
                    {food_row, all_eaten, eat_ready}, 128'(0));
            end
            @(negedge clk);
            chk("restart_done", {eat_ready, pellets_left, score_bcd},
                {1'b1, 13'(m_pel), to_bcd(m_score)});
            @(negedge clk);
            chk("restart_row2", 128'(food_row), 128'(model_row(2)));
        end else begin
            wait_ready();
            chk("restart_state", {pellets_left, score_bcd},
                {13'(m_pel), to_bcd(m_score)});
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got no finish expected finish before 2ms");
        $fatal(1, "watchdog");
    end

    initial begin
        int x;
        int y;
        rst        = 1'b1;
        restart    = 1'b0;
        eat_valid  = 1'b0;
        eat_x      = '0;
        eat_y      = '0;
        food_idx_y = 6'd2;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {food_row, eat_ready, eat_done, eat_hit, score_bcd, pellets_left, all_eaten},
            128'(0));
        rst = 1'b0;
        fill_model();
        m_score = 0;
        for (int i = 1; i <= 60; i++) begin
            @(negedge clk);
            if (i == 59) chk("init_not_ready", 128'(eat_ready), 128'(0));
            if (i == 60) chk("init_done", {eat_ready, pellets_left}, {1'b1, 13'd300});
        end

        check_row(2);
        check_row(3);
        check_row(61);

        do_eat(6, 2, 1'b0);
        wait_idle();
        check_row(2);
        do_eat(6, 2, 1'b0);
        do_eat(5, 2, 1'b0);
        do_eat(90, 2, 1'b0);
        do_eat(10, 62, 1'b0);
        wait_idle();
        check_row(2);

        done_cycs.delete();
        do_eat(10, 2, 1'b1);
        do_eat(14, 2, 1'b1);
        do_eat(127, 63, 1'b1);
        eat_valid = 1'b0;
        wait_idle();
        chk("burst_count", 128'(done_cycs.size()), 128'(3));
        if (done_cycs.size() == 3) begin
            chk("burst_gap1", 128'(done_cycs[1] - done_cycs[0]), 128'(3));
            chk("burst_gap2", 128'(done_cycs[2] - done_cycs[1]), 128'(3));
        end

        repeat (60) begin
            if ($urandom_range(0, 3) == 0) begin
                x = int'($urandom_range(0, 127));
                y = int'($urandom_range(0, 63));
            end else begin
                x = 4 * int'($urandom_range(0, 19)) + 2;
                y = 4 * int'($urandom_range(0, 14)) + 2;
            end
            do_eat(x, y, 1'b0);
        end
        wait_idle();
        repeat (5) check_row(int'($urandom_range(0, 63)));

        eat_all();
        chk("all_eaten", {all_eaten, pellets_left}, {1'b1, 13'd0});
        do_restart(1'b1);

        wait_ready();
        eat_valid = 1'b1;
        eat_x     = 7'd22;
        eat_y     = 6'd22;
        @(posedge clk);
        #1;
        eat_valid = 1'b0;
        @(negedge clk);
        restart = 1'b1;
        @(posedge clk);
        #1;
        restart = 1'b0;
        fill_model();
        wait_ready();
        chk("restart_in_read", {pellets_left, score_bcd},
            {13'(m_pel), to_bcd(m_score)});
        check_row(22);

        eat_valid = 1'b1;
        eat_x     = 7'd2;
        eat_y     = 6'd2;
        @(posedge clk);
        #1;
        eat_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_score = 0;
        fill_model();
        wait_ready();
        chk("rst_in_write", {pellets_left, score_bcd}, {13'(m_pel), 16'h0000});
        check_row(2);

        while (m_score < 9999) begin
            eat_all();
            do_restart(1'b0);
        end
        chk("score_saturated", 128'(score_bcd), 128'(16'h9999));
        do_eat(2, 2, 1'b0);
        wait_idle();

        chk("queue_empty", 128'(exp_q.size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
